load_return_unit: RTL and testbench
===================================

Name: load_return_unit

Overview:
- Read-side counterpart of the store byte-mask path in the memory stage.
- Records the attributes of each issued load (size, signedness, address low bits, destination register) in an in-order queue.
- Consumes returning 32-bit memory read words, extracts and extends the addressed byte, halfword or word, and presents the result to writeback through a valid/ready handshake.
- Holds up to DEPTH outstanding loads and one registered writeback result.

Parameters:
DEPTH, 2, outstanding-load queue entries; power of 2, at least 2
RD_W, 4, destination register address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ReqValid  in  1  load issued to memory this cycle
ReqReady  out  1  queue can accept a load attribute entry
ReqByteOrWord  in  1  1 = byte load, 0 = word load (ignored when ReqHalfword = 1)
ReqHalfword  in  1  1 = halfword load; overrides ReqByteOrWord
ReqSigned  in  1  1 = sign-extend byte/halfword, 0 = zero-extend
ReqAddrLow  in  2  address bits [1:0]
ReqRd  in  RD_W  destination register
MemRespValid  in  1  read data valid
MemRespData  in  32  aligned read word, little-endian lanes
MemRespReady  out  1  response accepted when high together with MemRespValid
WbValid  out  1  result valid
WbReady  in  1  writeback accepts result
WbData  out  32  extracted, extended data
WbRd  out  RD_W  destination register for WbData
WbMisaligned  out  1  halfword load with address bit 0 = 1
Outstanding  out  $clog2(DEPTH+1)  queued (unanswered) loads

Behaviour:
- Reset, synchronous and active-high:
  - count = 0; read and write pointers = 0.
  - WbValid, WbData, WbRd and WbMisaligned = 0.
  - ReqReady and MemRespReady are forced to 0 while reset is high.
  - Queue contents are don't-care.
  - Reset mid-operation discards all queued entries and the output register. In-flight memory responses after reset are the memory side's responsibility.
- Push:
  - Occurs on ReqValid && ReqReady. The entry stored is {ByteOrWord, Halfword, Signed, AddrLow, Rd}, written at the write pointer, which then increments mod DEPTH.
  - ReqReady = (count < DEPTH). When the queue is full, ReqReady = 0 even if a pop happens in the same cycle (no full bypass).
- Pop:
  - MemRespReady = (count > 0) && (!WbValid || WbReady), using registered count. A push in the same cycle cannot satisfy a response, so there is no empty bypass.
  - Response accepted → the head entry is popped and the read pointer increments mod DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - A response arriving while count = 0 is not accepted (MemRespReady = 0) and is held off.
- Output register:
  - Loaded on response acceptance; WbValid = 1 the following cycle (latency 1).
  - Cleared on WbValid && WbReady with no new acceptance. Back-to-back acceptance with WbReady = 1 sustains 1 result per cycle.
  - WbData, WbRd and WbMisaligned are stable while WbValid && !WbReady.
- Extraction, with A = entry AddrLow and D = MemRespData:
  - Halfword (takes precedence): h = D[16*A[1] +: 16]; WbData = Signed ? sign-extended h : zero-extended h; WbMisaligned = A[0].
  - Byte: b = D[8*A +: 8], extended per Signed; WbMisaligned = 0.
  - Word: WbData = D rotated right by 8*A (A = 0 → D unchanged); Signed ignored; WbMisaligned = 0.
- Outstanding = count. Ordering is strictly in-order; there are no tags.

Decomposition:
- Shared memory-stage package holds:
  - load size encoding constants, mirroring the store mask: word = {Halfword = 0, ByteOrWord = 0}, byte = {0, 1}, halfword = {1, x};
  - a packed struct for the queue entry;
  - the constant WORD_W = 32.
- One combinational sub-module, load_extract: inputs entry fields plus the 32-bit word; outputs data and misaligned flag.
- The top level holds the queue, counters, handshakes and output register.

Test Plan:
- Byte signed, A = 2'b11, D = 0x80_12_34_56 → WbData = 0xFFFFFF80; same with Signed = 0 → 0x00000080; WbValid 1 cycle after acceptance.
- Halfword signed, A = 2'b10, D = 0x9ABC_1234 → WbData = 0xFFFF9ABC, WbMisaligned = 0. With A = 2'b01 → WbData = 0x00001234 (zero-extend case), WbMisaligned = 1.
- Word, A = 2'b01, D = 0x11223344 → WbData = 0x44112233; A = 0 → 0x11223344.
- Full and ordering with DEPTH = 2:
  - Push Rd = 3, then Rd = 5 → ReqReady = 0 and Outstanding = 2; a third ReqValid is not accepted.
  - Two responses → WbRd = 3 then 5, in order.
- Backpressure and empty boundaries:
  - WbReady = 0 with WbValid = 1 → MemRespReady = 0 and outputs held.
  - MemRespValid with count = 0 → MemRespReady = 0.
  - Push plus pop in the same cycle leaves Outstanding unchanged.
- Reset mid-operation: reset asserted with Outstanding = 2 and WbValid = 1 → next cycle Outstanding = 0, WbValid = 0, WbData = 0, ReqReady = 1 after reset deasserts.

Source files
------------

// File: rtl/load_return_unit_pkg.sv
// Shared memory-stage definitions: load size encoding and the load queue entry layout.
package load_return_unit_pkg;

   localparam int unsigned WORD_W = 32;

   // {Halfword, ByteOrWord} encoding, mirrors the store byte-mask path; halfword ignores bit 0
   localparam logic [1:0] LD_SIZE_WORD = 2'b00;
   localparam logic [1:0] LD_SIZE_BYTE = 2'b01;
   localparam logic [1:0] LD_SIZE_HALF = 2'b10;

   typedef struct packed {
      logic       byte_or_word;
      logic       halfword;
      logic       sgn;
      logic [1:0] addr_low;
   } ld_attr_t;

endpackage

// File: rtl/load_return_unit_load_extract.sv
// Selects and extends the addressed byte, halfword or rotated word from a read word.
module load_extract
   import load_return_unit_pkg::*;
(
   input  logic              i_byte_or_word,
   input  logic              i_halfword,
   input  logic              i_signed,
   input  logic [1:0]        i_addr_low,
   input  logic [WORD_W-1:0] i_word,
   output logic [WORD_W-1:0] o_data,
   output logic              o_misaligned
);

   logic [15:0] w_half;
   logic [7:0]  w_byte;
   logic [WORD_W-1:0] w_rot;

   always_comb begin
      w_half = i_addr_low[1] ? i_word[31:16] : i_word[15:0];
      unique case (i_addr_low)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      unique case (i_addr_low)
         2'd0:    w_rot = i_word;
         2'd1:    w_rot = {i_word[7:0],  i_word[31:8]};
         2'd2:    w_rot = {i_word[15:0], i_word[31:16]};
         default: w_rot = {i_word[23:0], i_word[31:24]};
      endcase
   end

   always_comb begin
      o_data       = w_rot;
      o_misaligned = 1'b0;
      if (i_halfword) begin
         o_data       = {{16{i_signed & w_half[15]}}, w_half};
         o_misaligned = i_addr_low[0];
      end else if ({i_halfword, i_byte_or_word} == LD_SIZE_BYTE) begin
         o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      end
   end

endmodule

// File: rtl/load_return_unit.sv
// In-order load attribute queue matched against memory read responses, with one registered
// writeback result.
module load_return_unit
   import load_return_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned RD_W  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ReqValid,
   output logic                       ReqReady,
   input  logic                       ReqByteOrWord,
   input  logic                       ReqHalfword,
   input  logic                       ReqSigned,
   input  logic [1:0]                 ReqAddrLow,
   input  logic [RD_W-1:0]            ReqRd,
   input  logic                       MemRespValid,
   input  logic [WORD_W-1:0]          MemRespData,
   output logic                       MemRespReady,
   output logic                       WbValid,
   input  logic                       WbReady,
   output logic [WORD_W-1:0]          WbData,
   output logic [RD_W-1:0]            WbRd,
   output logic                       WbMisaligned,
   output logic [$clog2(DEPTH+1)-1:0] Outstanding
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   ld_attr_t          r_attr [DEPTH];
   logic [RD_W-1:0]   r_rd   [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_wb_valid;
   logic [WORD_W-1:0] r_wb_data;
   logic [RD_W-1:0]   r_wb_rd;
   logic              r_wb_mis;

   logic              w_push;
   logic              w_pop;
   ld_attr_t          w_head;
   logic [WORD_W-1:0] w_ext_data;
   logic              w_ext_mis;

   // Both readies use registered state only: no full bypass, no empty bypass
   assign ReqReady     = !reset && (r_count < CW'(DEPTH));
   assign MemRespReady = !reset && (r_count != '0) && (!r_wb_valid || WbReady);
   assign w_push       = ReqValid && ReqReady;
   assign w_pop        = MemRespValid && MemRespReady;
   assign w_head       = r_attr[r_rd_ptr];

   load_extract u_extract (
      .i_byte_or_word (w_head.byte_or_word),
      .i_halfword     (w_head.halfword),
      .i_signed       (w_head.sgn),
      .i_addr_low     (w_head.addr_low),
      .i_word         (MemRespData),
      .o_data         (w_ext_data),
      .o_misaligned   (w_ext_mis)
   );

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_attr[r_wr_ptr] <= '{byte_or_word: ReqByteOrWord, halfword: ReqHalfword,
                               sgn: ReqSigned, addr_low: ReqAddrLow};
         r_rd[r_wr_ptr]   <= ReqRd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wb_valid <= 1'b0;
         r_wb_data  <= '0;
         r_wb_rd    <= '0;
         r_wb_mis   <= 1'b0;
      end else if (w_pop) begin
         r_wb_valid <= 1'b1;
         r_wb_data  <= w_ext_data;
         r_wb_rd    <= r_rd[r_rd_ptr];
         r_wb_mis   <= w_ext_mis;
      end else if (WbReady) begin
         r_wb_valid <= 1'b0;
      end
   end

   assign WbValid      = r_wb_valid;
   assign WbData       = r_wb_data;
   assign WbRd         = r_wb_rd;
   assign WbMisaligned = r_wb_mis;
   assign Outstanding  = r_count;

endmodule

// File: tb/tb_load_return_unit.sv
// Directed bench for load_return_unit with DEPTH = 2: extraction, ordering, handshakes, reset.
module tb_load_return_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic        ReqByteOrWord = 1'b0;
   logic        ReqHalfword = 1'b0;
   logic        ReqSigned = 1'b0;
   logic [1:0]  ReqAddrLow = 2'd0;
   logic [3:0]  ReqRd = 4'd0;
   logic        MemRespValid = 1'b0;
   logic [31:0] MemRespData = 32'd0;
   logic        MemRespReady;
   logic        WbValid;
   logic        WbReady = 1'b1;
   logic [31:0] WbData;
   logic [3:0]  WbRd;
   logic        WbMisaligned;
   logic [1:0]  Outstanding;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_return_unit #(.DEPTH(2), .RD_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .ReqValid      (ReqValid),
      .ReqReady      (ReqReady),
      .ReqByteOrWord (ReqByteOrWord),
      .ReqHalfword   (ReqHalfword),
      .ReqSigned     (ReqSigned),
      .ReqAddrLow    (ReqAddrLow),
      .ReqRd         (ReqRd),
      .MemRespValid  (MemRespValid),
      .MemRespData   (MemRespData),
      .MemRespReady  (MemRespReady),
      .WbValid       (WbValid),
      .WbReady       (WbReady),
      .WbData        (WbData),
      .WbRd          (WbRd),
      .WbMisaligned  (WbMisaligned),
      .Outstanding   (Outstanding)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic bw, input logic hw, input logic sg, input logic [1:0] a,
                       input logic [3:0] rd);
      ReqValid = 1'b1; ReqByteOrWord = bw; ReqHalfword = hw; ReqSigned = sg;
      ReqAddrLow = a; ReqRd = rd;
      check_eq("push_ready", {31'd0, ReqReady}, 32'd1);
      step();
      ReqValid = 1'b0;
   endtask

   task automatic resp(input logic [31:0] d);
      MemRespValid = 1'b1; MemRespData = d;
      check_eq("resp_ready", {31'd0, MemRespReady}, 32'd1);
      step();
      MemRespValid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic bw, input logic hw, input logic sg,
                          input logic [1:0] a, input logic [3:0] rd, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_mis);
      push(bw, hw, sg, a, rd);
      check_eq({tag, "_outst1"}, {30'd0, Outstanding}, 32'd1);
      check_eq({tag, "_notyet"}, {31'd0, WbValid}, 32'd0);
      resp(d);
      check_eq({tag, "_valid"}, {31'd0, WbValid}, 32'd1);
      check_eq({tag, "_data"}, WbData, exp_d);
      check_eq({tag, "_rd"}, {28'd0, WbRd}, {28'd0, rd});
      check_eq({tag, "_mis"}, {31'd0, WbMisaligned}, {31'd0, exp_mis});
      check_eq({tag, "_outst0"}, {30'd0, Outstanding}, 32'd0);
      step();
      check_eq({tag, "_drained"}, {31'd0, WbValid}, 32'd0);
   endtask

   initial begin
      step();
      check_eq("rst_reqready", {31'd0, ReqReady}, 32'd0);
      check_eq("rst_respready", {31'd0, MemRespReady}, 32'd0);
      step();
      reset = 1'b0;
      #1;
      check_eq("rst_outst", {30'd0, Outstanding}, 32'd0);
      check_eq("rst_wbvalid", {31'd0, WbValid}, 32'd0);
      check_eq("rst_wbdata", WbData, 32'd0);
      check_eq("rst_wbrd", {28'd0, WbRd}, 32'd0);
      check_eq("rst_wbmis", {31'd0, WbMisaligned}, 32'd0);
      check_eq("rst_reqready_after", {31'd0, ReqReady}, 32'd1);

      // Extraction vectors: {bw, hw, sg}, A, data
      do_load("byte_s",  1'b1, 1'b0, 1'b1, 2'b11, 4'd1, 32'h80123456, 32'hFFFFFF80, 1'b0);
      do_load("byte_u",  1'b1, 1'b0, 1'b0, 2'b11, 4'd2, 32'h80123456, 32'h00000080, 1'b0);
      do_load("half_s",  1'b0, 1'b1, 1'b1, 2'b10, 4'd3, 32'h9ABC1234, 32'hFFFF9ABC, 1'b0);
      do_load("half_mis", 1'b1, 1'b1, 1'b1, 2'b01, 4'd4, 32'h9ABC1234, 32'h00001234, 1'b1);
      do_load("word_a1", 1'b0, 1'b0, 1'b1, 2'b01, 4'd5, 32'h11223344, 32'h44112233, 1'b0);
      do_load("word_a0", 1'b0, 1'b0, 1'b0, 2'b00, 4'd6, 32'h11223344, 32'h11223344, 1'b0);
      do_load("byte_a1", 1'b1, 1'b0, 1'b1, 2'b01, 4'd7, 32'h0000F500, 32'hFFFFFFF5, 1'b0);

      // Response with empty queue is held off
      MemRespValid = 1'b1; MemRespData = 32'hDEADBEEF;
      #1;
      check_eq("empty_respready", {31'd0, MemRespReady}, 32'd0);
      step();
      check_eq("empty_no_wb", {31'd0, WbValid}, 32'd0);
      MemRespValid = 1'b0;

      // Fill and ordering
      push(1'b0, 1'b0, 1'b0, 2'b00, 4'd3);
      push(1'b0, 1'b0, 1'b0, 2'b00, 4'd5);
      check_eq("full_reqready", {31'd0, ReqReady}, 32'd0);
      check_eq("full_outst", {30'd0, Outstanding}, 32'd2);
      ReqValid = 1'b1; ReqRd = 4'd7;
      step();
      ReqValid = 1'b0;
      check_eq("full_third_rejected", {30'd0, Outstanding}, 32'd2);

      // Backpressure: first result held while WbReady is low
      WbReady = 1'b0;
      resp(32'hAAAAAAAA);
      check_eq("bp_valid", {31'd0, WbValid}, 32'd1);
      check_eq("bp_rd_first", {28'd0, WbRd}, 32'd3);
      check_eq("bp_outst", {30'd0, Outstanding}, 32'd1);
      MemRespValid = 1'b1; MemRespData = 32'hBBBBBBBB;
      #1;
      check_eq("bp_respready", {31'd0, MemRespReady}, 32'd0);
      step();
      check_eq("bp_hold_data", WbData, 32'hAAAAAAAA);
      check_eq("bp_hold_rd", {28'd0, WbRd}, 32'd3);
      check_eq("bp_hold_outst", {30'd0, Outstanding}, 32'd1);
      WbReady = 1'b1;
      #1;
      check_eq("bp_release_ready", {31'd0, MemRespReady}, 32'd1);
      step();
      MemRespValid = 1'b0;
      check_eq("order_rd_second", {28'd0, WbRd}, 32'd5);
      check_eq("order_data_second", WbData, 32'hBBBBBBBB);
      check_eq("order_valid_b2b", {31'd0, WbValid}, 32'd1);
      check_eq("order_outst0", {30'd0, Outstanding}, 32'd0);
      step();
      check_eq("order_drained", {31'd0, WbValid}, 32'd0);

      // Push and pop in the same cycle
      push(1'b0, 1'b0, 1'b0, 2'b00, 4'd2);
      ReqValid = 1'b1; ReqRd = 4'd4; ReqAddrLow = 2'b00; ReqHalfword = 1'b0;
      ReqByteOrWord = 1'b0;
      MemRespValid = 1'b1; MemRespData = 32'h12345678;
      #1;
      check_eq("pp_reqready", {31'd0, ReqReady}, 32'd1);
      check_eq("pp_respready", {31'd0, MemRespReady}, 32'd1);
      step();
      ReqValid = 1'b0; MemRespValid = 1'b0;
      check_eq("pp_outst", {30'd0, Outstanding}, 32'd1);
      check_eq("pp_rd", {28'd0, WbRd}, 32'd2);
      check_eq("pp_data", WbData, 32'h12345678);
      resp(32'h0000CAFE);
      check_eq("pp_rd_next", {28'd0, WbRd}, 32'd4);
      step();

      // Reset mid-operation with a held result and a full queue
      push(1'b0, 1'b0, 1'b0, 2'b00, 4'd1);
      WbReady = 1'b0;
      resp(32'h55555555);
      push(1'b0, 1'b0, 1'b0, 2'b00, 4'd8);
      push(1'b0, 1'b0, 1'b0, 2'b00, 4'd9);
      check_eq("mid_outst2", {30'd0, Outstanding}, 32'd2);
      check_eq("mid_valid", {31'd0, WbValid}, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_reqready", {31'd0, ReqReady}, 32'd0);
      check_eq("mid_rst_respready", {31'd0, MemRespReady}, 32'd0);
      step();
      check_eq("mid_rst_outst", {30'd0, Outstanding}, 32'd0);
      check_eq("mid_rst_valid", {31'd0, WbValid}, 32'd0);
      check_eq("mid_rst_data", WbData, 32'd0);
      reset = 1'b0;
      WbReady = 1'b1;
      #1;
      check_eq("mid_rst_reqready_after", {31'd0, ReqReady}, 32'd1);
      do_load("post_rst", 1'b1, 1'b0, 1'b0, 2'b10, 4'd10, 32'h00AB0000, 32'h000000AB, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
